// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the decode/EX pipeline and the HI/LO unit.
//   Start : one-cycle request, qualifies Op/In0/In1
//   Op    : 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   In0   : rs operand (forwarded)
//   In1   : rt operand (forwarded)
//   Flush : aborts the EX instruction and any in-flight operation
//   Busy  : high while a mult/div is in progress
//   HI/LO : architectural HI/LO read data for mfhi/mflo
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] In0;
    logic [31:0] In1;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, Op, In0, In1, Flush,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, Op, In0, In1, Flush,
        output Busy, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit in EX.
// The product/quotient is computed in the start cycle and parked in pending registers;
// a down-counter then models the multi-cycle latency and the result is committed to
// HI/LO only on the final cycle, so a flush or reset leaves no architectural trace.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of mult_div_unit_if (Start/Op/In0/In1/Flush in, Busy/HI/LO out)
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = ($clog2(MaxCycles) > 4) ? $clog2(MaxCycles) : 4;

    typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       phi_q, phi_d, plo_q, plo_d;
    logic              dz_q, dz_d;   // pending divide had a zero divisor

    // Datapath, evaluated on the live operands; only captured in the start cycle.
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               is_signed_div, a_neg, b_neg, div_zero;
    logic [31:0]        div_a, div_b, quo_mag, rem_mag, quo, rem;

    always_comb begin
        prod_s = $signed({{32{bus.In0[31]}}, bus.In0}) * $signed({{32{bus.In1[31]}}, bus.In1});
        prod_u = {32'b0, bus.In0} * {32'b0, bus.In1};

        // Signed divide done on magnitudes so that 0x80000000 / -1 wraps cleanly.
        is_signed_div = (bus.Op == 3'd2);
        a_neg         = is_signed_div && bus.In0[31];
        b_neg         = is_signed_div && bus.In1[31];
        div_zero      = (bus.In1 == 32'd0);
        div_a         = a_neg ? (32'd0 - bus.In0) : bus.In0;
        div_b         = div_zero ? 32'd1 : (b_neg ? (32'd0 - bus.In1) : bus.In1);
        quo_mag       = div_a / div_b;
        rem_mag       = div_a % div_b;
        quo           = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
        rem           = a_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.Start && !bus.Flush) begin
                    case (bus.Op)
                        3'd0: begin
                            {phi_d, plo_d} = prod_s;
                            state_d        = StMult;
                            cnt_d          = CntW'(MULT_CYCLES - 1);
                        end
                        3'd1: begin
                            {phi_d, plo_d} = prod_u;
                            state_d        = StMult;
                            cnt_d          = CntW'(MULT_CYCLES - 1);
                        end
                        3'd2, 3'd3: begin
                            phi_d   = rem;
                            plo_d   = quo;
                            dz_d    = div_zero;
                            state_d = StDiv;
                            cnt_d   = CntW'(DIV_CYCLES - 1);
                        end
                        3'd4:    hi_d = bus.In0;
                        3'd5:    lo_d = bus.In0;
                        default: ;
                    endcase
                end
            end
            StMult, StDiv: begin
                if (bus.Flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!(state_q == StDiv && dz_q)) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.Busy = (state_q != StIdle);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int MultCycles = 5;
    localparam int DivCycles  = 10;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit_if bus ();

    mult_div_unit #(
        .MULT_CYCLES (MultCycles),
        .DIV_CYCLES  (DivCycles)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, update the reference HI/LO, then check latency and results.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              exp_n;
        int              n;
        exp_n = 0;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sp = sa * sb;
                exp_hi = sp[63:32];
                exp_lo = sp[31:0];
                exp_n  = MultCycles;
            end
            3'd1: begin
                ua = {32'b0, a};
                ub = {32'b0, b};
                up = ua * ub;
                exp_hi = up[63:32];
                exp_lo = up[31:0];
                exp_n  = MultCycles;
            end
            3'd2: begin
                exp_n = DivCycles;
                if (b != 0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    sp = sa / sb;
                    exp_lo = sp[31:0];
                    sp = sa % sb;
                    exp_hi = sp[31:0];
                end
            end
            3'd3: begin
                exp_n = DivCycles;
                if (b != 0) begin
                    ua = {32'b0, a};
                    ub = {32'b0, b};
                    up = ua / ub;
                    exp_lo = up[31:0];
                    up = ua % ub;
                    exp_hi = up[31:0];
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.In0   = a;
        bus.In1   = b;
        @(negedge clk);
        bus.Start = 1'b0;
        n = 0;
        while (bus.Busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_n));
        check({tag, " HI"}, {32'b0, bus.HI}, {32'b0, exp_hi});
        check({tag, " LO"}, {32'b0, bus.LO}, {32'b0, exp_lo});
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        tests     = 0;
        fails     = 0;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        bus.Start = 1'b0;
        bus.Op    = 3'd0;
        bus.In0   = 32'd0;
        bus.In1   = 32'd0;
        bus.Flush = 1'b0;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        #2;
        check("reset Busy", {63'b0, bus.Busy}, 64'd0);
        check("reset HI", {32'b0, bus.HI}, 64'd0);
        check("reset LO", {32'b0, bus.LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed plan
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult -2*3");
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu");
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        do_op(3'd3, 32'd7, 32'd0, "divu by zero");
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        do_op(3'd6, 32'hDEAD_BEEF, 32'd1, "op6 noop");

        // mthi/mtlo on consecutive cycles
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = 3'd4;
        bus.In0   = 32'h1234_5678;
        @(negedge clk);
        exp_hi = 32'h1234_5678;
        check("mthi HI", {32'b0, bus.HI}, {32'b0, exp_hi});
        check("mthi Busy", {63'b0, bus.Busy}, 64'd0);
        bus.Op  = 3'd5;
        bus.In0 = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.Start = 1'b0;
        exp_lo = 32'h9ABC_DEF0;
        check("mtlo LO", {32'b0, bus.LO}, {32'b0, exp_lo});
        check("mtlo HI held", {32'b0, bus.HI}, {32'b0, exp_hi});
        check("mtlo Busy", {63'b0, bus.Busy}, 64'd0);

        // mthi while busy is dropped
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = 3'd3;
        bus.In0   = 32'd9;
        bus.In1   = 32'd0;
        @(negedge clk);
        bus.Op  = 3'd4;
        bus.In0 = 32'hCAFE_F00D;
        @(negedge clk);
        bus.Start = 1'b0;
        check("mthi while busy HI", {32'b0, bus.HI}, {32'b0, exp_hi});
        repeat (12) @(negedge clk);
        check("mthi busy after commit HI", {32'b0, bus.HI}, {32'b0, exp_hi});
        check("mthi busy after commit LO", {32'b0, bus.LO}, {32'b0, exp_lo});

        // Flush on busy cycle 4 of a divide
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = 3'd2;
        bus.In0   = 32'd100;
        bus.In1   = 32'd7;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check("flush Busy", {63'b0, bus.Busy}, 64'd0);
        repeat (12) @(negedge clk);
        check("flush HI", {32'b0, bus.HI}, {32'b0, exp_hi});
        check("flush LO", {32'b0, bus.LO}, {32'b0, exp_lo});

        // Flush on the commit cycle of a multiply
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = 3'd0;
        bus.In0   = 32'd1000;
        bus.In1   = 32'd1000;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge clk);
        check("flush last Busy before", {63'b0, bus.Busy}, 64'd1);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check("flush last Busy", {63'b0, bus.Busy}, 64'd0);
        check("flush last HI", {32'b0, bus.HI}, {32'b0, exp_hi});
        check("flush last LO", {32'b0, bus.LO}, {32'b0, exp_lo});

        // Flush coincident with Start
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.Op    = 3'd4;
        bus.In0   = 32'h5555_AAAA;
        @(negedge clk);
        bus.Op = 3'd0;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        check("flush+start Busy", {63'b0, bus.Busy}, 64'd0);
        check("flush+start HI", {32'b0, bus.HI}, {32'b0, exp_hi});

        // Asynchronous reset mid-multiply
        do_op(3'd1, 32'h0001_0000, 32'h0003_0000, "multu pre-reset");
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = 3'd0;
        bus.In0   = 32'd3;
        bus.In1   = 32'd4;
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("async reset Busy", {63'b0, bus.Busy}, 64'd0);
        check("async reset HI", {32'b0, bus.HI}, 64'd0);
        check("async reset LO", {32'b0, bus.LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(3'd0, 32'd3, 32'hFFFF_FFFC, "mult after reset");

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin
                    ra = 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                default: ;
            endcase
            do_op(rop, ra, rb, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- HI/LO multiply/divide unit in EX. Responder to the decode stage's `Start` / mult-type request.
- Accepts mult, multu, div, divu, mthi and mtlo, runs multi-cycle operations, and exposes `Busy` to the hazard logic.
- `HI`/`LO` read data goes to the EX result mux (mfhi/mflo).
- Only the final commit updates `HI`/`LO`. A flush aborts an in-flight operation without side effects.

Parameters:
MULT_CYCLES  5   cycles `Busy` stays high for mult/multu (>=1)
DIV_CYCLES   10  cycles `Busy` stays high for div/divu (>=1)

Ports:
clk     in   1   rising-edge clock
reset   in   1   asynchronous, active-low reset (0 = reset)
Start   in   1   one-cycle request; qualifies `Op`
Op      in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op)
In0     in   32  rs operand (forwarded value)
In1     in   32  rt operand (forwarded value)
Flush   in   1   exception/eret flush of the EX instruction and any in-flight op
Busy    out  1   1 while a mult/div is in progress
HI      out  32  architectural HI
LO      out  32  architectural LO

Behaviour:
- States: IDLE, MULT, DIV. Down-counter `cnt`, 4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES).
- Pending result registers: `pHI`, `pLO`.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, HI=0, LO=0, pHI=0, pLO=0.
  - `Busy`=0 immediately.
- `Busy` = (state != IDLE). Purely state-derived; it does not include `Start`. The hazard unit ORs in `Start` itself.
- At an edge in IDLE with Start=1, Flush=0:
  - mult: pHI:pLO <= signed(In0)*signed(In1), 64-bit. state<=MULT, cnt<=MULT_CYCLES-1.
  - multu: same as mult, unsigned product.
  - div: pLO <= quotient, truncated toward zero. pHI <= remainder, sign of dividend (In0). state<=DIV, cnt<=DIV_CYCLES-1.
  - divu: same as div, unsigned.
  - div/divu with In1==0: enter DIV as normal. Commit leaves HI/LO unchanged (no trap).
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - mthi: HI<=In0 at this edge, stays IDLE. mtlo: LO<=In0 likewise.
  - Op 6/7: no effect.
- At each edge in MULT/DIV with Flush=0:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: HI<=pHI, LO<=pLO (except the divide-by-zero case), state<=IDLE.
  - Net latency: `Busy` is high for exactly N cycles after the start edge; new HI/LO are visible in the cycle `Busy` falls.
- Start while Busy=1 is ignored (the hazard unit stalls every mult-type instruction while `Busy`). This includes mthi/mtlo.
- Flush=1 at an edge:
  - state<=IDLE, cnt<=0.
  - HI/LO not written, including when cnt==0 in the same cycle.
  - Any Start in the same cycle is ignored.
- Commit and new Start coincident: impossible (Busy=1 that cycle); Start is dropped per the rule above.
- Reset asserted mid-operation: abort immediately, all registers to reset values.
- No X propagation: `HI`/`LO` hold their value in all states except commit/mthi/mtlo.

Test Plan:
- Reset, then Start Op=0, In0=0xFFFFFFFE (-2), In1=3 -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- Op=1 multu, In0=0xFFFFFFFF, In1=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- Op=2 div, In0=-7 (0xFFFFFFF9), In1=2 -> Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then divu 7/0 -> after 10 cycles HI/LO unchanged.
- mthi In0=0x12345678 then mtlo In0=0x9ABCDEF0 on consecutive cycles -> HI/LO updated next edge each, Busy never asserts. Repeat mthi while Busy -> HI unchanged.
- Start div, assert Flush on cycle 4 of Busy -> Busy=0 next cycle, HI/LO keep prior values. Flush coincident with Start -> no op starts.
- Start mult, drive reset=0 asynchronously mid-count (between edges) -> Busy, HI, LO go to 0 without waiting for clk. After release, a new mult completes normally.
